// File: rtl/cla_mp_add_seq.sv
// Multi-precision add/subtract sequencer reusing one 16-bit CLA slice
// over WORDS cycles, least-significant word first.
module cla_mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    input  logic                  sub,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int KW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WORDS-1:0][15:0] a_q, b_q, sum_q;
    logic                   carry_q;
    logic                   ovf_q;
    logic [KW-1:0]          k_q;

    logic [15:0] sa, sb, ss;
    logic [15:0] g, p, c;
    logic [3:0]  gg, gp, gc;
    logic        sc;
    logic        accept, last;

    assign sa   = a_q[k_q];
    assign sb   = b_q[k_q];
    assign last = (k_q == KW'(WORDS - 1));

    // Two-level lookahead: 4-bit groups, then carries across groups.
    always_comb begin
        g  = sa & sb;
        p  = sa ^ sb;
        gg = '0;
        gp = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = carry_q;
        gc[1] = gg[0] | (gp[0] & carry_q);
        gc[2] = gg[1] | (gp[1] & gg[0])
              | (gp[1] & gp[0] & carry_q);
        gc[3] = gg[2] | (gp[2] & gg[1])
              | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & carry_q);
        sc    = gg[3] | (gp[3] & gg[2])
              | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (&gp & carry_q);
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        ss = p ^ c;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = (state_q == IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            k_q     <= '0;
        end else if (state_q == RUN) begin
            sum_q[k_q] <= ss;
            carry_q    <= sc;
            k_q        <= last ? '0 : k_q + 1'b1;
            if (last)
                ovf_q <= ~(sa[15] ^ sb[15]) & (ss[15] ^ sa[15]);
        end
    end

    assign sum  = sum_q;
    assign cout = carry_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Bench for cla_mp_add_seq: directed cases on a 64-bit build,
// randomized ops on both a 64-bit and a 32-bit build.
module tb_cla_mp_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        in_valid4, in_ready4, sub4, cin4;
    logic        out_valid4, out_ready4, cout4, ovf4, busy4;
    logic [63:0] a4, b4, sum4;

    logic        in_valid2, in_ready2, sub2, cin2;
    logic        out_valid2, out_ready2, cout2, ovf2, busy2;
    logic [31:0] a2, b2, sum2;

    int errors = 0;
    int checks = 0;

    cla_mp_add_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .sub(sub4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
    );

    cla_mp_add_seq #(.WORDS(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .sub(sub2), .cin(cin2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on w-bit unsigned operands.
    function automatic void model(input int w, input logic [63:0] x0,
                                  input logic [63:0] y0, input logic s,
                                  input logic c, output logic [63:0] r,
                                  output logic co, output logic ov);
        logic [64:0] full;
        logic [63:0] mask, x, y;
        logic sx, sy, sr;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 1);
        x = x0 & mask;
        y = y0 & mask;
        if (s) begin
            r  = (x - y) & mask;
            co = (x >= y);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {64'd0, c};
            r    = full[63:0] & mask;
            co   = full[w];
        end
        sx = x[w-1];
        sy = y[w-1];
        sr = r[w-1];
        ov = s ? (sx != sy && sr != sx) : (sx == sy && sr != sx);
    endfunction

    // Accept one request on the 64-bit build and wait for out_valid.
    task automatic start4(input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic c, input string tag);
        int n;
        a4 = a; b4 = b; sub4 = s; cin4 = c; in_valid4 = 1'b1;
        check({tag, ".in_ready"}, in_ready4, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        a4 = ~a; b4 = ~b; sub4 = ~s; cin4 = ~c;
        n = 0;
        while (!out_valid4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, n, 4);
    endtask

    task automatic op4(input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic c, input int stall,
                       input logic [63:0] es, input logic eco,
                       input logic eov, input string tag);
        start4(a, b, s, c, tag);
        check({tag, ".sum"}, sum4, es);
        check({tag, ".cout"}, cout4, eco);
        check({tag, ".ovf"}, ovf4, eov);
        check({tag, ".busy"}, busy4, 1);
        repeat (stall) begin
            @(posedge clk); #1;
            check({tag, ".hold"}, {out_valid4, in_ready4, sum4[62:0]},
                  {1'b1, 1'b0, es[62:0]});
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check({tag, ".idle"}, {in_ready4, out_valid4, busy4}, 3'b100);
    endtask

    task automatic op2(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c, input int stall,
                       input string tag);
        logic [63:0] es;
        logic eco, eov;
        int n;
        model(32, {32'd0, a}, {32'd0, b}, s, c, es, eco, eov);
        a2 = a; b2 = b; sub2 = s; cin2 = c; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        a2 = $urandom; b2 = $urandom;
        n = 0;
        while (!out_valid2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, n, 2);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        check({tag, ".result"}, {out_valid2, cout2, ovf2, sum2},
              {1'b1, eco, eov, es[31:0]});
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check({tag, ".idle"}, in_ready2, 1);
    endtask

    initial begin
        logic [63:0] es, ra, rb, hold_sum;
        logic eco, eov, rs, rc, hold_c, hold_o;

        rst = 1'b1;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; sub4 = 0; cin4 = 0;
        in_valid2 = 0; out_ready2 = 0; a2 = 0; b2 = 0; sub2 = 0; cin2 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset", {in_ready4, out_valid4, busy4, cout4, ovf4, sum4},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0});
        check("reset.dut2", {in_ready2, out_valid2, sum2}, {2'b10, 32'd0});

        op4(64'h0000_0000_0000_FFFF, 64'h1, 0, 0, 0,
            64'h0000_0000_0001_0000, 0, 0, "xslice");
        op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 0,
            64'h0, 1, 0, "wrap");
        op4(64'd5, 64'd7, 1, 1, 0,
            64'hFFFF_FFFF_FFFF_FFFE, 0, 0, "sub");
        op4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 0,
            64'h8000_0000_0000_0000, 0, 1, "ovf");
        op4(64'd9, 64'd4, 1, 0, 1, 64'd5, 1, 0, "sub.noborrow");
        op4(64'h8000_0000_0000_0000, 64'h1, 1, 0, 0,
            64'h7FFF_FFFF_FFFF_FFFF, 1, 1, "sub.ovf");

        // Backpressure with a second request waiting.
        start4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
               0, 1, "bp");
        model(64, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              0, 1, es, eco, eov);
        check("bp.sum", sum4, es);
        hold_sum = sum4; hold_c = cout4; hold_o = ovf4;
        a4 = 64'd100; b4 = 64'd58; sub4 = 1; cin4 = 0; in_valid4 = 1;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp.hold",
                  {out_valid4, in_ready4, cout4, ovf4, sum4[59:0]},
                  {1'b1, 1'b0, hold_c, hold_o, hold_sum[59:0]});
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check("bp.release", {in_ready4, out_valid4, busy4}, 3'b100);
        op4(64'd100, 64'd58, 1, 0, 0, 64'd42, 1, 0, "bp.second");

        // Reset at k=2 discards the operation.
        a4 = 64'hFFFF_FFFF_FFFF_FFFF; b4 = 64'h1; sub4 = 0; cin4 = 0;
        in_valid4 = 1;
        @(posedge clk); #1;
        in_valid4 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst", {out_valid4, in_ready4, busy4, cout4, sum4},
              {1'b0, 1'b1, 1'b0, 1'b0, 64'd0});
        op4(64'd0, 64'd0, 0, 1, 0, 64'd1, 0, 0, "postrst");

        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            model(64, ra, rb, rs, rc, es, eco, eov);
            op4(ra, rb, rs, rc, $urandom_range(0, 2), es, eco, eov, "rnd4");
        end

        for (int i = 0; i < 200; i++) begin
            op2($urandom, $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), "rnd2");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cla_mp_add_seq.md
# cla_mp_add_seq

Multi-precision add/subtract sequencer built around the team's 16-bit carry-lookahead adder. It accepts one wide operand pair over a valid/ready handshake and reuses a single 16-bit CLA slice over `WORDS` consecutive cycles, least-significant word first. The slice carry is registered between cycles. The block sits between a requester (e.g. ALU front end) and a result consumer, trading latency for the area of one 16-bit adder.

## Interface
- `WORDS`, default 4: number of 16-bit slices. Operand width N = 16*WORDS. Legal range 2..16.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request carries valid operands.
- `in_ready`  out  1  block can accept a request.
- `a`  in  N  operand A.
- `b`  in  N  operand B.
- `sub`  in  1  1 = A-B, 0 = A+B+cin.
- `cin`  in  1  carry-in for add; ignored when `sub`=1.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes result.
- `sum`  out  N  result, two's-complement wrap modulo 2^N.
- `cout`  out  1  carry out of bit N-1 (for subtract: 1 = no borrow).
- `ovf`  out  1  signed overflow.
- `busy`  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`:
  - capture `a`, and `b` (bitwise inverted when `sub`=1);
  - load carry register with `sub ? 1 : cin`;
  - word index k=0; go to RUN.
- RUN, one word per cycle:
  - slice computes a[16k+15:16k] + b'[16k+15:16k] + carry;
  - write into `sum` word k; carry register takes the slice carry-out; k increments.
  - After word WORDS-1 the carry register holds `cout`; go to DONE.
- ovf is computed on the last word: (a_msb XNOR b'_msb) AND (sum_msb XOR a_msb). It is registered together with the final word.
- DONE: `out_valid`=1. `sum`, `cout` and `ovf` hold stable until `out_ready`=1, then go to IDLE on that edge.
- `in_ready` is combinational from state: 1 only in IDLE. Requests in RUN or DONE are not accepted and get no response. Requester must hold `in_valid`.
- Changes on `a`/`b`/`sub`/`cin` after the accept edge have no effect.
- `out_ready` outside DONE is ignored.
- `sum` lower words may be written during RUN; consumers sample only when `out_valid`=1.

## Timing
- Reset (any state, including mid-RUN or DONE) gives on the following cycle:
  - state IDLE, `in_ready`=1;
  - `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, `ovf`=0;
  - carry register and k = 0.
  - The in-flight operation is discarded, with no partial result presented.
- `rst` has priority over a simultaneous handshake.
- Accept at edge E0. Words 0..WORDS-1 are computed at edges E1..E_WORDS. `out_valid` rises after E_WORDS, so latency is WORDS cycles from the accept edge.
- Result taken at edge Ed (`out_valid`&`out_ready`); `in_ready` is high the cycle after Ed.
- Minimum issue interval is WORDS+2 cycles. No overlap of operations.
- Critical path is one 16-bit CLA plus the carry register. No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Test plan
- Cross-slice carry, WORDS=4, add, cin=0: a=0x0000_0000_0000_FFFF, b=0x1. Expect `sum`=0x0000_0000_0001_0000, `cout`=0, `ovf`=0, `out_valid` exactly 4 cycles after accept.
- Full wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, add. Expect `sum`=0, `cout`=1, `ovf`=0.
- Subtract and overflow:
  - a=5, b=7, sub=1 with cin=1 (must be ignored). Expect `sum`=0xFFFF_FFFF_FFFF_FFFE, `cout`=0, `ovf`=0.
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1, add. Expect `sum`=0x8000_0000_0000_0000, `ovf`=1, `cout`=0.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles in DONE. `out_valid`, `sum`, `cout` and `ovf` stay stable, `in_ready`=0, and a second request held on `in_valid` is not accepted.
  - Raise `out_ready`: IDLE next cycle, then the second request is accepted and its result is correct.
- Reset mid-RUN: assert `rst` for 1 cycle at k=2. Next cycle `out_valid`=0, `in_ready`=1, `sum`=0. Then a=0, b=0, cin=1 gives `sum`=1, `cout`=0.
- WORDS=2 build: random 200 add/sub ops with random `out_ready` stalls, checked against a 32-bit reference model.
